// File: rtl/fp_mul_pkg.sv
// Shared types for the sequential floating-point multiplier.
// FP_MUL_RNE_EN adds the ROUND state used by round-to-nearest-even.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    EXC_OK  = 2'b00,
    EXC_OVF = 2'b01,
    EXC_UNF = 2'b10,
    EXC_INV = 2'b11
  } exc_t;

`ifdef FP_MUL_RNE_EN
  typedef enum logic [2:0] {IDLE, CLASS, MUL, NORM, ROUND, DONE} fsm_t;
`else
  typedef enum logic [2:0] {IDLE, CLASS, MUL, NORM, DONE} fsm_t;
`endif

  typedef enum logic [2:0] {PP_ZERO, PP_POS1, PP_POS2, PP_NEG1, PP_NEG2} pp_sel_t;

  // Radix-4 Booth recode of {y[2i+1], y[2i], y[2i-1]}.
  function automatic pp_sel_t booth_sel(input logic [2:0] bits);
    pp_sel_t sel;
    case (bits)
      3'b001, 3'b010: sel = PP_POS1;
      3'b011:         sel = PP_POS2;
      3'b100:         sel = PP_NEG2;
      3'b101, 3'b110: sel = PP_NEG1;
      default:        sel = PP_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fp_mul_seq_booth_step.sv
// One radix-4 Booth step: add the recoded partial product to the
// accumulator, then arithmetic-shift {acc, mult} right by two.
module fp_booth_step
  import fp_mul_pkg::*;
#(
  parameter  int MAN_W = 10,
  localparam int NSTEP = (MAN_W + 3) / 2,
  localparam int AW    = MAN_W + 4,
  localparam int MB_W  = 2 * NSTEP + 1
) (
  input  logic [AW-1:0]   acc,
  input  logic [MB_W-1:0] mult,
  input  logic [AW-1:0]   pp_pos1,
  input  logic [AW-1:0]   pp_pos2,
  input  logic [AW-1:0]   pp_neg1,
  input  logic [AW-1:0]   pp_neg2,
  output logic [AW-1:0]   acc_nxt,
  output logic [MB_W-1:0] mult_nxt
);

  logic [AW-1:0]                pp;
  logic [AW-1:0]                sum;
  logic signed [AW+MB_W-1:0]    pair_sh;

  always_comb begin
    pp = '0;
    case (booth_sel(mult[2:0]))
      PP_POS1: pp = pp_pos1;
      PP_POS2: pp = pp_pos2;
      PP_NEG1: pp = pp_neg1;
      PP_NEG2: pp = pp_neg2;
      default: pp = '0;
    endcase
  end

  assign sum     = acc + pp;
  assign pair_sh = $signed({sum, mult}) >>> 2;
  assign {acc_nxt, mult_nxt} = pair_sh;

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle floating-point multiplier with iterative radix-4 Booth core.
// Default rounding is truncation; define FP_MUL_RNE_EN for round-to-nearest-even.
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter  int EXP_W = 5,
  parameter  int MAN_W = 10,
  localparam int FP_W  = 1 + EXP_W + MAN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] product,
  output logic [1:0]      exceptions
);

  localparam int NSTEP = (MAN_W + 3) / 2;
  localparam int CNT_W = $clog2(NSTEP + 1);
  localparam int AW    = MAN_W + 4;
  localparam int MB_W  = 2 * NSTEP + 1;
  localparam int PW    = 2 * (MAN_W + 1);
  localparam int EW2   = EXP_W + 2;

  localparam logic [CNT_W-1:0]      LAST_STEP = CNT_W'(NSTEP - 1);
  localparam logic signed [EW2-1:0] BIAS_E    = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] MAX_E     = EW2'((1 << EXP_W) - 2);
  localparam logic signed [EW2-1:0] ONE_E     = EW2'(1);

  fsm_t state, state_nxt;

  logic [FP_W-1:0] a_q, b_q;
  logic [AW-1:0]   acc, acc_nxt, pp_pos1, pp_pos2, pp_neg1, pp_neg2;
  logic [MB_W-1:0] mult, mult_nxt;
  logic [CNT_W-1:0] cnt;
  logic [FP_W-1:0] product_q;
  exc_t            exc_q;

  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             cls_inv, cls_zero, special;
  logic [AW-1:0]    mcand;
  logic [MB_W-1:0]  mult_init;

  assign sign_a = a_q[FP_W-1];
  assign sign_b = b_q[FP_W-1];
  assign exp_a  = a_q[FP_W-2 -: EXP_W];
  assign exp_b  = b_q[FP_W-2 -: EXP_W];
  assign man_a  = a_q[MAN_W-1:0];
  assign man_b  = b_q[MAN_W-1:0];

  // All-ones exponent (inf or NaN) and denormals are both rejected as invalid.
  assign cls_inv  = (&exp_a) || (&exp_b) ||
                    ((exp_a == '0) && (man_a != '0)) ||
                    ((exp_b == '0) && (man_b != '0));
  assign cls_zero = ((exp_a == '0) && (man_a == '0)) ||
                    ((exp_b == '0) && (man_b == '0));
  assign special  = cls_inv || cls_zero;

  assign mcand     = {{(AW-MAN_W-1){1'b0}}, 1'b1, man_a};
  assign mult_init = {{(MB_W-MAN_W-2){1'b0}}, 1'b1, man_b, 1'b0};

  fp_booth_step #(.MAN_W(MAN_W)) u_booth_step (
    .acc      (acc),
    .mult     (mult),
    .pp_pos1  (pp_pos1),
    .pp_pos2  (pp_pos2),
    .pp_neg1  (pp_neg1),
    .pp_neg2  (pp_neg2),
    .acc_nxt  (acc_nxt),
    .mult_nxt (mult_nxt)
  );

  // The low product bits sit in mult above its Booth guard bit, the rest in acc.
  logic [PW-1:0]          prod;
  logic                   norm_hi;
  logic [MAN_W-1:0]       man_n;
  logic signed [EW2-1:0]  e_n;
  logic                   sign_n;

  assign prod    = {acc[PW-2*NSTEP-1:0], mult[MB_W-1:1]};
  assign norm_hi = prod[PW-1];
  assign man_n   = norm_hi ? prod[PW-2 -: MAN_W] : prod[PW-3 -: MAN_W];
  assign sign_n  = sign_a ^ sign_b;
  assign e_n     = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_E +
                   $signed({{(EW2-1){1'b0}}, norm_hi});

  logic                  pk_sign;
  logic signed [EW2-1:0] pk_e;
  logic [MAN_W-1:0]      pk_man;
  logic [FP_W-1:0]       pk_product;
  exc_t                  pk_exc;

`ifdef FP_MUL_RNE_EN
  logic                  sign_q, guard_q, sticky_q;
  logic signed [EW2-1:0] e_q;
  logic [MAN_W-1:0]      man_q;
  logic                  guard_n, sticky_n, round_up;
  logic [MAN_W:0]        man_inc;

  assign guard_n  = norm_hi ? prod[PW-2-MAN_W] : prod[PW-3-MAN_W];
  assign sticky_n = norm_hi ? (|prod[PW-3-MAN_W:0]) : (|prod[PW-4-MAN_W:0]);
  assign round_up = guard_q & (sticky_q | man_q[0]);
  assign man_inc  = {1'b0, man_q} + {{MAN_W{1'b0}}, round_up};

  // A mantissa carry-out wraps man to zero and bumps the exponent.
  assign pk_sign = sign_q;
  assign pk_e    = e_q + $signed({{(EW2-1){1'b0}}, man_inc[MAN_W]});
  assign pk_man  = man_inc[MAN_W-1:0];
`else
  logic unused_low;

  assign unused_low = ^prod[PW-3-MAN_W:0];
  assign pk_sign    = sign_n;
  assign pk_e       = e_n;
  assign pk_man     = man_n;
`endif

  always_comb begin
    pk_product = '0;
    pk_exc     = EXC_OK;
    if (pk_e < ONE_E) begin
      pk_exc = EXC_UNF;
    end else if (pk_e > MAX_E) begin
      pk_exc = EXC_OVF;
    end else begin
      pk_product = {pk_sign, pk_e[EXP_W-1:0], pk_man};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CLASS;
      end
      CLASS: state_nxt = special ? DONE : MUL;
      MUL:   if (cnt == LAST_STEP) state_nxt = NORM;
`ifdef FP_MUL_RNE_EN
      NORM:  state_nxt = ROUND;
      ROUND: state_nxt = DONE;
`else
      NORM:  state_nxt = DONE;
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      mult      <= '0;
      pp_pos1   <= '0;
      pp_pos2   <= '0;
      pp_neg1   <= '0;
      pp_neg2   <= '0;
      cnt       <= '0;
      product_q <= '0;
      exc_q     <= EXC_OK;
`ifdef FP_MUL_RNE_EN
      sign_q    <= 1'b0;
      e_q       <= '0;
      man_q     <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
          end
        end
        CLASS: begin
          if (special) begin
            product_q <= '0;
            if (cls_inv) exc_q <= EXC_INV;
            else         exc_q <= EXC_OK;
          end else begin
            acc     <= '0;
            mult    <= mult_init;
            pp_pos1 <= mcand;
            pp_pos2 <= mcand << 1;
            pp_neg1 <= -mcand;
            pp_neg2 <= -(mcand << 1);
            cnt     <= '0;
          end
        end
        MUL: begin
          acc  <= acc_nxt;
          mult <= mult_nxt;
          cnt  <= cnt + CNT_W'(1);
        end
        NORM: begin
`ifdef FP_MUL_RNE_EN
          sign_q   <= sign_n;
          e_q      <= e_n;
          man_q    <= man_n;
          guard_q  <= guard_n;
          sticky_q <= sticky_n;
`else
          product_q <= pk_product;
          exc_q     <= pk_exc;
`endif
        end
`ifdef FP_MUL_RNE_EN
        ROUND: begin
          product_q <= pk_product;
          exc_q     <= pk_exc;
        end
`endif
        default: ;
      endcase
    end
  end

  assign product    = product_q;
  assign exceptions = exc_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed self-checking bench for fp_mul_seq at half precision.
// Honours FP_MUL_RNE_EN for the rounding vector and normal-path latency.
module tb_fp_mul_seq;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int FP_W  = 1 + EXP_W + MAN_W;
  localparam int NSTEP = (MAN_W + 3) / 2;
`ifdef FP_MUL_RNE_EN
  localparam int             LAT_N   = NSTEP + 3;
  localparam logic [15:0]    RND_EXP = 16'h3E02;
`else
  localparam int             LAT_N   = NSTEP + 2;
  localparam logic [15:0]    RND_EXP = 16'h3E01;
`endif
  localparam int LAT_S = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [FP_W-1:0] a, b;
  logic            out_valid;
  logic            out_ready;
  logic [FP_W-1:0] product;
  logic [1:0]      exceptions;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fp_mul_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .exceptions (exceptions)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts edges after the accept edge until out_valid, bounded at 40.
  task automatic waitResult(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!out_valid && cycles < 40);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                               input logic [15:0] exp_p, input logic [1:0] exp_e, input int exp_lat);
    int cycles;
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = op_a;
    b = op_b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~op_a;
    b = ~op_b;
    waitResult(tag, cycles);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
    checkOutput({tag, "_product"}, 32'(product), 32'(exp_p));
    checkOutput({tag, "_exc"}, 32'(exceptions), 32'(exp_e));
    @(posedge clk); #1;
    checkOutput({tag, "_release"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #12;
    checkOutput("rst_in_ready",   32'(in_ready),   32'd1);
    checkOutput("rst_out_valid",  32'(out_valid),  32'd0);
    checkOutput("rst_product",    32'(product),    32'd0);
    checkOutput("rst_exceptions", 32'(exceptions), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    applyStimulus("mul_5x6",     16'h4500, 16'h4600, 16'h4F80, 2'b00, LAT_N);
    applyStimulus("mul_3x3",     16'h4200, 16'h4200, 16'h4880, 2'b00, LAT_N);
    applyStimulus("mul_neg3x3",  16'hC200, 16'h4200, 16'hC880, 2'b00, LAT_N);
    applyStimulus("mul_1x1",     16'h3C00, 16'h3C00, 16'h3C00, 2'b00, LAT_N);
    applyStimulus("mul_maxman",  16'h3FFF, 16'h3FFF, 16'h43FE, 2'b00, LAT_N);
    applyStimulus("inf",         16'h7C00, 16'h44E6, 16'h0000, 2'b11, LAT_S);
    applyStimulus("nan_zero",    16'h7E00, 16'h0000, 16'h0000, 2'b11, LAT_S);
    applyStimulus("zero",        16'h0000, 16'h44E6, 16'h0000, 2'b00, LAT_S);
    applyStimulus("negzero",     16'h8000, 16'h44E6, 16'h0000, 2'b00, LAT_S);
    applyStimulus("denorm",      16'h011E, 16'h44E6, 16'h0000, 2'b11, LAT_S);
    applyStimulus("denorm_zero", 16'h011E, 16'h0000, 16'h0000, 2'b11, LAT_S);
    applyStimulus("ovf",         16'h5A00, 16'h5E00, 16'h0000, 2'b01, LAT_N);
    applyStimulus("emax_ok",     16'h7800, 16'h3C00, 16'h7800, 2'b00, LAT_N);
    applyStimulus("emax_ovf",    16'h7800, 16'h4000, 16'h0000, 2'b01, LAT_N);
    applyStimulus("norm_ovf",    16'h7A00, 16'h3E00, 16'h0000, 2'b01, LAT_N);
    applyStimulus("unf",         16'h0500, 16'h0906, 16'h0000, 2'b10, LAT_N);
    applyStimulus("emin_ok",     16'h0400, 16'h3C00, 16'h0400, 2'b00, LAT_N);
    applyStimulus("emin_unf",    16'h0400, 16'h3800, 16'h0000, 2'b10, LAT_N);
    applyStimulus("round_tie",   16'h3E00, 16'h3C01, RND_EXP,  2'b00, LAT_N);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    a = 16'h4500;
    b = 16'h4600;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitResult("bp", cycles);
    checkOutput("bp_latency", 32'(cycles), 32'(LAT_N));
    for (int i = 0; i < 5; i++) begin
      a = 16'h7C00;
      b = 16'h3C00;
      in_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_hold_valid",   32'(out_valid),  32'd1);
      checkOutput("bp_hold_product", 32'(product),    32'h4F80);
      checkOutput("bp_hold_exc",     32'(exceptions), 32'd0);
      checkOutput("bp_in_ready",     32'(in_ready),   32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release", 32'({out_valid, in_ready}), 32'b01);
    @(posedge clk); #1;
    checkOutput("bp_no_ghost", 32'({out_valid, in_ready}), 32'b01);

    $display("[TB] reset during MUL");
    a = 16'h4500;
    b = 16'h4600;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_in_ready",  32'(in_ready),   32'd1);
    checkOutput("mrst_out_valid", 32'(out_valid),  32'd0);
    checkOutput("mrst_product",   32'(product),    32'd0);
    checkOutput("mrst_exc",       32'(exceptions), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (NSTEP + 4) @(posedge clk);
    #1;
    checkOutput("mrst_no_ghost", 32'({out_valid, in_ready}), 32'b01);
    applyStimulus("post_rst_3x3", 16'h4200, 16'h4200, 16'h4880, 2'b00, LAT_N);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
